// File: rtl/timer_host_master.sv
// Avalon-MM initiator that programs the interval-timer slave,
// services its irq, counts timeouts and reads 32-bit snapshots.
module timer_host_master #(
  parameter int COUNT_W = 16,
  parameter bit SAT     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_start,
  input  logic [31:0]        cmd_period,
  input  logic               cmd_continuous,
  input  logic               cmd_stop,
  input  logic               cmd_snap,
  output logic               busy,
  output logic               running,
  output logic [COUNT_W-1:0] tick_count,
  output logic [31:0]        snap_value,
  output logic               snap_valid,
  output logic [2:0]         address,
  output logic               chipselect,
  output logic               write_n,
  output logic [15:0]        writedata,
  input  logic [15:0]        readdata,
  input  logic               irq
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, WR_CLR,
    WR_SNAP, RD_L, CAP_L, RD_H, CAP_H
  } state_t;

  state_t state, next;
  logic        hold;
  logic [31:0] period_q;
  logic        cont_q;
  logic [15:0] snap_l;
  logic        nxt_cs;
  logic        nxt_we;
  logic [2:0]  nxt_addr;
  logic [15:0] nxt_data;

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        // hold masks the stale irq level left over from the clear write
        if (irq && !hold)   next = WR_CLR;
        else if (cmd_stop)  next = WR_STOP;
        else if (cmd_start) next = WR_PL;
        else if (cmd_snap)  next = WR_SNAP;
      end
      WR_PL:   next = WR_PH;
      WR_PH:   next = WR_CTL;
      WR_CTL:  next = IDLE;
      WR_STOP: next = IDLE;
      WR_CLR:  next = IDLE;
      WR_SNAP: next = RD_L;
      RD_L:    next = CAP_L;
      CAP_L:   next = RD_H;
      RD_H:    next = CAP_H;
      CAP_H:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign busy = !reset && (state != IDLE || next != IDLE);

  // Bus outputs are registered from the next state
  always_comb begin
    nxt_cs   = 1'b0;
    nxt_we   = 1'b0;
    nxt_addr = address;
    nxt_data = writedata;
    unique case (next)
      WR_PL: begin
        nxt_cs   = 1'b1;
        nxt_we   = 1'b1;
        nxt_addr = 3'd2;
        nxt_data = cmd_period[15:0];
      end
      WR_PH: begin
        nxt_cs   = 1'b1;
        nxt_we   = 1'b1;
        nxt_addr = 3'd3;
        nxt_data = period_q[31:16];
      end
      WR_CTL: begin
        nxt_cs   = 1'b1;
        nxt_we   = 1'b1;
        nxt_addr = 3'd1;
        nxt_data = {12'h0, 1'b0, 1'b1, cont_q, 1'b1};
      end
      WR_STOP: begin
        nxt_cs   = 1'b1;
        nxt_we   = 1'b1;
        nxt_addr = 3'd1;
        nxt_data = 16'h0008;
      end
      WR_CLR: begin
        nxt_cs   = 1'b1;
        nxt_we   = 1'b1;
        nxt_addr = 3'd0;
        nxt_data = 16'h0000;
      end
      WR_SNAP: begin
        nxt_cs   = 1'b1;
        nxt_we   = 1'b1;
        nxt_addr = 3'd4;
        nxt_data = 16'h0000;
      end
      RD_L: begin
        nxt_cs   = 1'b1;
        nxt_addr = 3'd4;
      end
      RD_H: begin
        nxt_cs   = 1'b1;
        nxt_addr = 3'd5;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      address    <= 3'd0;
      writedata  <= 16'h0;
      hold       <= 1'b0;
      period_q   <= 32'h0;
      cont_q     <= 1'b0;
      running    <= 1'b0;
      tick_count <= '0;
      snap_l     <= 16'h0;
      snap_value <= 32'h0;
      snap_valid <= 1'b0;
    end else begin
      state      <= next;
      chipselect <= nxt_cs;
      write_n    <= !nxt_we;
      address    <= nxt_addr;
      writedata  <= nxt_data;
      hold       <= (state == WR_CLR);
      snap_valid <= 1'b0;
      if (state == IDLE && next == WR_PL) begin
        period_q <= cmd_period;
        cont_q   <= cmd_continuous;
      end
      if (state == WR_CTL) running <= 1'b1;
      else if (state == WR_STOP) running <= 1'b0;
      if (state == WR_CLR) begin
        if (!(SAT && (&tick_count)))
          tick_count <= tick_count + 1'b1;
      end
      if (state == CAP_L) snap_l <= readdata;
      if (state == CAP_H) begin
        snap_value <= {readdata, snap_l};
        snap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_host_master.sv
// Scoreboard bench for timer_host_master with a behavioural
// timer slave; a saturating twin runs in lockstep.
module tb_timer_host_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_period = 32'h0;
  logic        cmd_continuous = 1'b0;
  logic        cmd_stop = 1'b0;
  logic        cmd_snap = 1'b0;
  logic        busy, running, snap_valid;
  logic [3:0]  tick_count;
  logic [31:0] snap_value;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  logic        busy1, running1, snap_valid1;
  logic [3:0]  tick1;
  logic [31:0] snap_value1;
  logic [2:0]  address1;
  logic        chipselect1, write_n1;
  logic [15:0] writedata1;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  logic [31:0] snap_q[$];
  logic [3:0]  t_wrap = 4'd0;
  logic [3:0]  t_sat = 4'd0;

  // slave model
  logic        set_to = 1'b0;
  logic        to_flag;
  logic        clr_d;
  logic [31:0] slave_cnt = 32'h0;
  logic [31:0] slave_snap;

  always #5 clk = ~clk;

  timer_host_master #(.COUNT_W(4), .SAT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous), .cmd_stop(cmd_stop),
    .cmd_snap(cmd_snap), .busy(busy), .running(running),
    .tick_count(tick_count), .snap_value(snap_value),
    .snap_valid(snap_valid), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  timer_host_master #(.COUNT_W(4), .SAT(1'b1)) dut_sat (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous), .cmd_stop(cmd_stop),
    .cmd_snap(cmd_snap), .busy(busy1), .running(running1),
    .tick_count(tick1), .snap_value(snap_value1),
    .snap_valid(snap_valid1), .address(address1),
    .chipselect(chipselect1), .write_n(write_n1),
    .writedata(writedata1), .readdata(readdata), .irq(irq)
  );

  assign irq = to_flag;

  // clear reaches the irq line one cycle late
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      to_flag    <= 1'b0;
      clr_d      <= 1'b0;
      slave_snap <= 32'h0;
      readdata   <= 16'h0;
    end else begin
      clr_d <= chipselect && !write_n && address == 3'd0;
      if (set_to) to_flag <= 1'b1;
      else if (clr_d) to_flag <= 1'b0;
      if (chipselect && !write_n && address == 3'd4)
        slave_snap <= slave_cnt;
      if (chipselect && write_n)
        readdata <= (address == 3'd4) ? slave_snap[15:0] :
                    (address == 3'd5) ? slave_snap[31:16] : 16'h0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_wr(input logic [2:0] a,
                                  input logic [15:0] d);
    exp_q.push_back({1'b1, a, d});
  endfunction

  function automatic void push_rd(input logic [2:0] a);
    exp_q.push_back({1'b0, a, 16'h0});
  endfunction

  always @(negedge clk) begin
    if (!reset && chipselect) begin
      if (exp_q.size() == 0) chk("bus_unexpected", 1, 0);
      else chk("bus", {!write_n, address, write_n ? 16'h0 : writedata},
               exp_q.pop_front());
    end
    if (!reset && snap_valid) begin
      if (snap_q.size() == 0) chk("snap_unexpected", 1, 0);
      else chk("snap", snap_value, snap_q.pop_front());
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic issue(input int kind);
    @(negedge clk);
    cmd_start = (kind == 0);
    cmd_stop  = (kind == 1);
    cmd_snap  = (kind == 2);
    #1 chk("busy_accept", busy, 1);
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_snap  = 1'b0;
    wait_idle();
  endtask

  task automatic bump();
    t_wrap = t_wrap + 4'd1;
    if (t_sat != 4'hF) t_sat = t_sat + 4'd1;
  endtask

  task automatic fire_irq();
    push_wr(3'd0, 16'h0);
    bump();
    @(negedge clk);
    set_to = 1'b1;
    @(negedge clk);
    set_to = 1'b0;
    @(negedge clk);
    wait_idle();
  endtask

  task automatic chk_reset_vals();
    chk("rst_cs", chipselect, 0);
    chk("rst_wn", write_n, 1);
    chk("rst_addr", address, 0);
    chk("rst_wd", writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_run", running, 0);
    chk("rst_tick", tick_count, 0);
    chk("rst_snap", snap_value, 0);
    chk("rst_sv", snap_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    cmd_period = 32'h0001_86A0;
    cmd_continuous = 1'b1;
    push_wr(3'd2, 16'h86A0);
    push_wr(3'd3, 16'h0001);
    push_wr(3'd1, 16'h0007);
    issue(0);
    chk("running_start", running, 1);

    fire_irq();
    chk("tick_one", tick_count, t_wrap);
    repeat (4) @(negedge clk);
    chk("tick_no_double", tick_count, t_wrap);

    slave_cnt = 32'h0000_1234;
    push_wr(3'd4, 16'h0);
    push_rd(3'd4);
    push_rd(3'd5);
    snap_q.push_back(32'h0000_1234);
    issue(2);
    chk("snap_hold", snap_value, 32'h0000_1234);

    push_wr(3'd0, 16'h0);
    bump();
    @(negedge clk);
    set_to = 1'b1;
    @(negedge clk);
    set_to = 1'b0;
    cmd_stop = 1'b1;
    #1 chk("busy_irq_stop", busy, 1);
    @(negedge clk);
    cmd_stop = 1'b0;
    chk("busy_clr", busy, 1);
    wait_idle();
    chk("stop_dropped", running, 1);
    chk("tick_two", tick_count, t_wrap);

    push_wr(3'd1, 16'h0008);
    issue(1);
    chk("running_stop", running, 0);

    cmd_period = 32'h0;
    cmd_continuous = 1'b0;
    push_wr(3'd2, 16'h0);
    push_wr(3'd3, 16'h0);
    push_wr(3'd1, 16'h0005);
    issue(0);
    chk("running_p0", running, 1);

    for (int i = 0; i < 14; i++) fire_irq();
    chk("tick_wrap16", tick_count, t_wrap);
    chk("tick_sat16", tick1, t_sat);
    fire_irq();
    chk("tick_wrap17", tick_count, t_wrap);
    chk("tick_sat17", tick1, t_sat);

    slave_cnt = 32'hDEAD_BEEF;
    push_wr(3'd4, 16'h0);
    push_rd(3'd4);
    push_rd(3'd5);
    snap_q.push_back(32'hDEAD_BEEF);
    issue(2);

    push_wr(3'd4, 16'h0);
    @(negedge clk);
    cmd_snap = 1'b1;
    @(negedge clk);
    cmd_snap = 1'b0;
    @(posedge clk);
    #1 chk("rdl_cs", {chipselect, write_n, address}, {1'b1, 1'b1, 3'd4});
    reset = 1'b1;
    #1 chk("abort_cs", chipselect, 0);
    chk("abort_wn", write_n, 1);
    chk("abort_busy", busy, 0);
    chk("wq_empty", exp_q.size(), 0);
    exp_q.delete();
    snap_q.delete();
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_idle", busy, 0);
    chk("sq_empty", snap_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
